branch_resolve: RTL and testbench
=================================

# branch_resolve

Backend counterpart of the frontend static predictor. Fetch pushes each instruction's PC and predicted next PC into an in-order in-flight queue. Execute later reports the actual next PC for the oldest instruction. This block compares the two, retires matches, and on mismatch issues a one-cycle redirect to fetch, empties the queue and holds a fixed flush window.

## Interface
Parameters:
- `DEPTH`, 4: in-flight queue entries; power of two, at least 2.
- `FLUSH_CYCLES`, 2: cycles `flushing` stays high after a mispredict; at least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push_valid`  in  1  fetch presents an entry.
- `push_pc`  in  32  fetched instruction PC.
- `push_pred`  in  32  predicted next PC.
- `push_ready`  out  1  queue accepts a push this cycle.
- `resolve_valid`  in  1  execute resolves the oldest entry.
- `resolve_next`  in  32  actual next PC of the oldest entry.
- `redirect`  out  1  one-cycle pulse: fetch restarts at `redirect_pc`.
- `redirect_pc`  out  32  correct restart address.
- `flushing`  out  1  flush window active.
- `error`  out  1  sticky: a resolve arrived while the queue was empty.
- `mispredict_count`  out  32  present only with `BRANCH_STATS_EN`.

## Operation
- States: `RUN`, `FLUSH`. Reset enters `RUN`.
- Push handshake: a push is accepted when `push_valid && push_ready`. The condition is `push_ready = (state==RUN) && (count<DEPTH)`, computed combinationally from registered state only.
- Resolve in `RUN` with count>0 compares the head `pred` with `resolve_next` over all 32 bits:
  - Equal: pop the head. No other effect.
  - Not equal: clear the queue (head, tail and count all 0). Register `redirect_pc <= resolve_next`, pulse `redirect`, load the flush counter with `FLUSH_CYCLES`, go to `FLUSH`, and increment the mispredict counter.
- Push and pop in the same cycle: count is unchanged. A full queue may accept a push in the same cycle as a matching resolve only if `push_ready` was already high. Full means no push that cycle.
- Push in the same cycle as a mispredicting resolve: the clear wins and the pushed entry is discarded.
- Resolve with count==0 in `RUN`: ignored, and `error` is set until reset.
- In `FLUSH`: `resolve_valid` is ignored and pushes are refused. The counter decrements each cycle. When it reaches 0, the block returns to `RUN`.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Queue storage is not reset; only pointers, count and state are reset.

## Timing
- Reset values: `redirect`=0, `redirect_pc`=0, `flushing`=0, `error`=0, `push_ready`=1 in the cycle after reset deasserts, `mispredict_count`=0.
- Redirect latency: a mismatch sampled on edge N makes `redirect` high for the single cycle after edge N, with `redirect_pc` valid in that cycle.
- `redirect_pc` holds its value until the next mispredict.
- `flushing` is high exactly `FLUSH_CYCLES` cycles, starting in the same cycle as `redirect`.
- `push_ready` is 0 throughout the flush window. It returns to 1 in the first cycle after `flushing` falls.
- Reset asserted mid-flush: the block is back in `RUN` with an empty queue on the next edge. Any pending redirect is dropped.
- Pop and retire take effect at the sampling edge. A push and a resolve of the same entry cannot occur in the same cycle: a resolve needs count>0 before that edge.

## Configuration
- `BRANCH_STATS_EN` defined:
  - The `mispredict_count` port exists: a 32-bit register cleared by reset, +1 per mispredict, wrapping at 2^32.
- Not defined:
  - The port and register are absent. All other behaviour is identical.

## Structure
- Shared package `pipeline_pkg` holds:
  - `addr_t` (logic [31:0]).
  - Struct `pred_entry_t` {pc, pred}.
  - Enum `resolve_state_t` {RUN, FLUSH}.
- The package is shared with fetch and execute.
- Sub-module `branch_fifo`: a parameterised synchronous FIFO of `pred_entry_t` with push, pop, clear, count, full and empty. Clear has priority over push.
- `branch_resolve` holds the FSM, comparator, flush counter, error and stats logic.

## Test plan
- Push {0x00400000, 0x00400004}, then resolve_next=0x00400004 → no redirect, count returns to 0, `error`=0.
- Push {0x00400010, 0x00400040}, then resolve_next=0x00400014 → `redirect`=1 for one cycle on the next cycle, `redirect_pc`=0x00400014, `flushing` high 2 cycles, `push_ready`=0 meanwhile, count=0, `mispredict_count`=1.
- Push 4 entries with no resolve → `push_ready`=0. A 5th push is held. A matching resolve then frees one slot, and `push_ready`=1 the next cycle.
- Push and mispredicting resolve in the same cycle, with 2 entries queued → count=0 after the edge and the pushed entry is absent.
- Resolve with an empty queue → `error`=1 and stays high through subsequent traffic until `reset`.
- Mispredict, then assert `reset` in the first flush cycle → next cycle `flushing`=0, `push_ready`=1, `redirect_pc`=0, counters zero.

Source files
------------

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types for the fetch / execute / branch-resolve slice of the pipeline.
//   addr_t          : 32-bit instruction address
//   pred_entry_t    : one in-flight instruction {pc, predicted next pc}
//   resolve_state_t : branch_resolve FSM states {RUN, FLUSH}
// -----------------------------------------------------------------------------
package pipeline_pkg;

   typedef logic [31:0] addr_t;

   typedef struct packed {
      addr_t pc;
      addr_t pred;
   } pred_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } resolve_state_t;

endpackage

// File: rtl/branch_fifo.sv
// -----------------------------------------------------------------------------
// branch_fifo
// Synchronous in-order FIFO of pred_entry_t used as the in-flight queue.
// Ports:
//   clk, reset    : clock and synchronous active-high reset (pointers/count)
//   push, push_data : enqueue an entry (ignored when full)
//   pop           : dequeue the head entry (ignored when empty)
//   clear         : empty the queue; wins over a same-cycle push
//   head          : current oldest entry
//   count         : occupancy, log2(DEPTH)+1 bits
//   full, empty   : occupancy flags
// -----------------------------------------------------------------------------
module branch_fifo
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  pred_entry_t                push_data,
   input  logic                       pop,
   input  logic                       clear,
   output pred_entry_t                head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);

   pred_entry_t        mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping. Pointers are exactly log2(DEPTH)
   // bits wide so they wrap modulo DEPTH on their own. A clear resets
   // everything to the empty state in one cycle, discarding any push.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (PTR_W+1)'(1);
         end else if (do_pop && !do_push) begin
            count <= count - (PTR_W+1)'(1);
         end
      end
   end

   // Entry storage carries no reset; stale contents are never visible
   // because the pointers and count are reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Backend checker for the static branch predictor. Fetch pushes {pc, pred}
// into an in-order queue; execute reports the actual next pc of the oldest
// entry. A match retires the entry; a mismatch redirects fetch for one cycle,
// empties the queue and holds a FLUSH_CYCLES-long flush window.
//
// Optional feature: define BRANCH_STATS_EN to add the mispredict_count port.
//
// Ports:
//   clk, reset       : clock and synchronous active-high reset
//   push_valid/push_pc/push_pred/push_ready : fetch enqueue handshake
//   resolve_valid/resolve_next              : execute resolves the oldest entry
//   redirect, redirect_pc : one-cycle restart pulse and restart address
//   flushing         : flush window active
//   error            : sticky, a resolve arrived with an empty queue
//   mispredict_count : (BRANCH_STATS_EN only) wrapping mispredict tally
// -----------------------------------------------------------------------------
module branch_resolve
   import pipeline_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push_valid,
   input  addr_t       push_pc,
   input  addr_t       push_pred,
   output logic        push_ready,
   input  logic        resolve_valid,
   input  addr_t       resolve_next,
   output logic        redirect,
   output addr_t       redirect_pc,
   output logic        flushing,
   output logic        error
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0] mispredict_count
`endif
);

   localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

   resolve_state_t          state;
   logic [FLUSH_W-1:0]      flush_cnt;
   pred_entry_t             head;
   pred_entry_t             push_entry;
   logic [$clog2(DEPTH):0]  queue_count;
   logic                    queue_full;
   logic                    queue_empty;
   logic                    resolve_live;
   logic                    hit;
   logic                    miss;
   logic                    unused_head_pc;

   // Handshake and compare decode. push_ready depends only on registered
   // state so fetch sees a stable ready for the whole cycle. Resolves are
   // only acted on in RUN with a non-empty queue.
   assign push_ready     = (state == RUN) && !queue_full;
   assign flushing       = (state == FLUSH);
   assign resolve_live   = (state == RUN) && resolve_valid && !queue_empty;
   assign hit            = resolve_live && (head.pred == resolve_next);
   assign miss           = resolve_live && (head.pred != resolve_next);
   assign push_entry     = '{pc: push_pc, pred: push_pred};
   assign unused_head_pc = ^{head.pc, queue_count};

   branch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_valid && push_ready),
      .push_data (push_entry),
      .pop       (hit),
      .clear     (miss),
      .head      (head),
      .count     (queue_count),
      .full      (queue_full),
      .empty     (queue_empty)
   );

   // Control FSM. A mispredict in RUN loads the flush counter and enters
   // FLUSH; the window lasts FLUSH_CYCLES cycles, so the last FLUSH cycle is
   // the one where the counter reads 1. redirect is a registered pulse that
   // coincides with the first FLUSH cycle; redirect_pc holds until the next
   // mispredict. error latches an empty-queue resolve until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         flush_cnt   <= '0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         error       <= 1'b0;
      end else begin
         redirect <= miss;
         if (state == RUN) begin
            if (miss) begin
               redirect_pc <= resolve_next;
               flush_cnt   <= FLUSH_W'(FLUSH_CYCLES);
               state       <= FLUSH;
            end
            if (resolve_valid && queue_empty) begin
               error <= 1'b1;
            end
         end else begin
            if (flush_cnt <= FLUSH_W'(1)) begin
               flush_cnt <= '0;
               state     <= RUN;
            end else begin
               flush_cnt <= flush_cnt - FLUSH_W'(1);
            end
         end
      end
   end

`ifdef BRANCH_STATS_EN
   // Mispredict tally; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         mispredict_count <= '0;
      end else if (miss) begin
         mispredict_count <= mispredict_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
// Self-checking bench for branch_resolve. A queue-based reference model of
// the in-flight entries and flush window predicts each cycle's outputs; the
// prediction is pushed to a scoreboard when stimulus is driven and popped and
// compared once the DUT has taken the edge.
// -----------------------------------------------------------------------------
module tb_branch_resolve;
   import pipeline_pkg::*;

   localparam int DEPTH        = 4;
   localparam int FLUSH_CYCLES = 2;

   typedef struct {
      logic        redirect;
      logic [31:0] redirect_pc;
      logic        flushing;
      logic        error;
      logic [31:0] count;
      logic [31:0] mcnt;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        push_valid;
   addr_t       push_pc;
   addr_t       push_pred;
   logic        push_ready;
   logic        resolve_valid;
   addr_t       resolve_next;
   logic        redirect;
   addr_t       redirect_pc;
   logic        flushing;
   logic        error;
`ifdef BRANCH_STATS_EN
   logic [31:0] mispredict_count;
`endif

   int          checks;
   int          failures;

   exp_t        exp_q[$];
   logic [31:0] m_q[$];
   logic        m_flushing;
   int          m_flush;
   logic        m_err;
   logic [31:0] m_rpc;
   logic [31:0] m_mcnt;

   branch_resolve #(
      .DEPTH        (DEPTH),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .push_valid       (push_valid),
      .push_pc          (push_pc),
      .push_pred        (push_pred),
      .push_ready       (push_ready),
      .resolve_valid    (resolve_valid),
      .resolve_next     (resolve_next),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .flushing         (flushing),
      .error            (error)
`ifdef BRANCH_STATS_EN
      ,
      .mispredict_count (mispredict_count)
`endif
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare the DUT's post-edge outputs with the oldest scoreboard entry.
   task automatic compareHead();
      exp_t e;
      if (exp_q.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         checkOutput("redirect", {31'd0, redirect}, {31'd0, e.redirect});
         checkOutput("redirect_pc", redirect_pc, e.redirect_pc);
         checkOutput("flushing", {31'd0, flushing}, {31'd0, e.flushing});
         checkOutput("error", {31'd0, error}, {31'd0, e.error});
         checkOutput("count", {29'd0, dut.queue_count}, e.count);
`ifdef BRANCH_STATS_EN
         checkOutput("mispredict_count", mispredict_count, e.mcnt);
`endif
      end
   endtask

   function automatic exp_t snapshot(input logic redir);
      exp_t e;
      e.redirect    = redir;
      e.redirect_pc = m_rpc;
      e.flushing    = m_flushing;
      e.error       = m_err;
      e.count       = m_q.size();
      e.mcnt        = m_mcnt;
      return e;
   endfunction

   task automatic resetDut();
      reset         = 1'b1;
      push_valid    = 1'b0;
      push_pc       = '0;
      push_pred     = '0;
      resolve_valid = 1'b0;
      resolve_next  = '0;
      m_q.delete();
      m_flushing = 1'b0;
      m_flush    = 0;
      m_err      = 1'b0;
      m_rpc      = '0;
      m_mcnt     = '0;
      exp_q.push_back(snapshot(1'b0));
      tick();
      reset = 1'b0;
      compareHead();
      checkOutput("reset_push_ready", {31'd0, push_ready}, 32'd1);
   endtask

   // Drive one cycle of stimulus, advance the model, queue the expectation,
   // then compare after the edge.
   task automatic applyStimulus(input logic pv, input logic [31:0] pc,
                                input logic [31:0] pred, input logic rv,
                                input logic [31:0] rnext);
      logic exp_ready;
      logic accept;
      logic had_entries;
      logic redir;
      push_valid    = pv;
      push_pc       = pc;
      push_pred     = pred;
      resolve_valid = rv;
      resolve_next  = rnext;
      exp_ready = !m_flushing && (m_q.size() < DEPTH);
      checkOutput("push_ready", {31'd0, push_ready}, {31'd0, exp_ready});
      accept      = pv && exp_ready;
      had_entries = (m_q.size() > 0);
      redir       = 1'b0;
      if (!m_flushing) begin
         if (rv && had_entries && (m_q[0] != rnext)) begin
            m_q.delete();
            m_rpc      = rnext;
            m_flushing = 1'b1;
            m_flush    = FLUSH_CYCLES;
            m_mcnt     = m_mcnt + 32'd1;
            redir      = 1'b1;
         end else begin
            if (rv && had_entries) void'(m_q.pop_front());
            if (rv && !had_entries) m_err = 1'b1;
            if (accept) m_q.push_back(pred);
         end
      end else begin
         m_flush--;
         if (m_flush == 0) m_flushing = 1'b0;
      end
      exp_q.push_back(snapshot(redir));
      tick();
      compareHead();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      logic [31:0] rn;
      checks   = 0;
      failures = 0;

      resetDut();

      $display("[TB] matching resolve");
      applyStimulus(1'b1, 32'h0040_0000, 32'h0040_0004, 1'b0, '0);
      applyStimulus(1'b0, '0, '0, 1'b1, 32'h0040_0004);

      $display("[TB] mispredict and flush window");
      applyStimulus(1'b1, 32'h0040_0010, 32'h0040_0040, 1'b0, '0);
      applyStimulus(1'b0, '0, '0, 1'b1, 32'h0040_0014);
      applyStimulus(1'b1, 32'h0000_1000, 32'h0000_1004, 1'b1, 32'h0000_1004);
      applyStimulus(1'b1, 32'h0000_1000, 32'h0000_1004, 1'b0, '0);
      idle(2);
      checkOutput("redirect_pc_hold", redirect_pc, 32'h0040_0014);

      $display("[TB] full queue backpressure");
      resetDut();
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b1, 32'h100 + 32'(i * 4), 32'h200 + 32'(i), 1'b0, '0);
      applyStimulus(1'b1, 32'h0000_0500, 32'h0000_0600, 1'b0, '0);
      applyStimulus(1'b0, '0, '0, 1'b1, 32'h0000_0200);
      checkOutput("ready_after_pop", {31'd0, push_ready}, 32'd1);
      idle(1);

      $display("[TB] push with mispredicting resolve");
      resetDut();
      applyStimulus(1'b1, 32'h10, 32'h100, 1'b0, '0);
      applyStimulus(1'b1, 32'h14, 32'h200, 1'b0, '0);
      applyStimulus(1'b1, 32'h18, 32'h300, 1'b1, 32'h999);
      idle(2);
      applyStimulus(1'b1, 32'h20, 32'h500, 1'b0, '0);
      applyStimulus(1'b0, '0, '0, 1'b1, 32'h500);

      $display("[TB] resolve on empty queue");
      applyStimulus(1'b0, '0, '0, 1'b1, 32'h1234);
      applyStimulus(1'b1, 32'h30, 32'h34, 1'b0, '0);
      applyStimulus(1'b0, '0, '0, 1'b1, 32'h34);
      idle(1);

      $display("[TB] reset in first flush cycle");
      applyStimulus(1'b1, 32'h40, 32'h44, 1'b0, '0);
      applyStimulus(1'b0, '0, '0, 1'b1, 32'h88);
      resetDut();

      $display("[TB] random traffic");
      for (int i = 0; i < 80; i++) begin
         rn = $urandom;
         if (m_q.size() > 0 && ($urandom_range(0, 4) != 0)) rn = m_q[0];
         applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 15),
                       1'($urandom_range(0, 1)), rn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
